cbs_conv3x3_act: RTL and testbench

// - Downstream stage of the CBS window front-end: consumes one padded 3x3 pixel window (9 x 8-bit) per handshake,

---
 rtl/cbs_conv3x3_act_if.sv | 23 ++
 rtl/cbs_conv3x3_act.sv | 169 ++++++++++++++++
 tb/tb_cbs_conv3x3_act.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cbs_conv3x3_act_if.sv
// Handshake, window and config bundle between the CBS window front-end and the conv/BN/activation stage.
interface cbs_conv3x3_act_if;
  logic               in_valid;
  logic               in_ready;
  logic [71:0]        window;
  logic               cfg_we;
  logic [3:0]         cfg_addr;
  logic [15:0]        cfg_data;
  logic               cfg_err;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  out_data;

  modport master (
    output in_valid, window, cfg_we, cfg_addr, cfg_data, out_ready,
    input  in_ready, cfg_err, out_valid, out_data
  );

  modport slave (
    input  in_valid, window, cfg_we, cfg_addr, cfg_data, out_ready,
    output in_ready, cfg_err, out_valid, out_data
  );
endinterface

// File: rtl/cbs_conv3x3_act.sv
// Serial 3x3 conv (one tap per cycle) + folded batch-norm + activation, one signed 8-bit feature per window.
// Build option: define CBS_SILU_EN for hard-SiLU activation; default is ReLU.
module cbs_conv3x3_act #(
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned SCALE_SH  = 8,
  parameter int unsigned FRAC_BITS = 4
) (
  input logic              clk,
  input logic              reset,
  cbs_conv3x3_act_if.slave bus
);
  localparam int unsigned NTAP  = 9;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned PRD_W = 17;
  localparam int unsigned CFG_W = 16;
  localparam int unsigned BN_W  = 40;
  localparam int unsigned ACT_W = 2 * ACC_W;
  localparam int unsigned OUT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MAC  = 3'd1,
    S_BN   = 3'd2,
    S_ACT  = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  logic [PIX_W-1:0]        r_pix [NTAP];
  logic signed [7:0]       r_w   [NTAP];
  logic signed [CFG_W-1:0] r_scale;
  logic signed [CFG_W-1:0] r_bias;
  logic [3:0]              r_tap;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_z;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic signed [OUT_W-1:0] r_out_data;
  logic                    r_cfg_err;

  logic w_accept, w_cfg_wr, w_cfg_drop;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and control strobes; config only lands in IDLE when no window is taken the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_cfg_wr    = 1'b0;
    w_cfg_drop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_MAC;
        end
        w_cfg_wr = bus.cfg_we & ~bus.in_valid;
      end
      S_MAC:   if (r_tap == 4'd8) w_state_nxt = S_BN;
      S_BN:    w_state_nxt = S_ACT;
      S_ACT:   w_state_nxt = S_HOLD;
      S_HOLD:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_cfg_drop = bus.cfg_we & ~w_cfg_wr;
  end

  // MAC: unsigned pixel times signed weight, sign-extended into the accumulator
  logic signed [PRD_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  assign w_prod     = $signed({1'b0, r_pix[r_tap]}) * r_w[r_tap];
  assign w_prod_ext = {{(ACC_W-PRD_W){w_prod[PRD_W-1]}}, w_prod};

  // Batch-norm in a 40-bit intermediate, saturated back to ACC_W
  logic signed [BN_W-1:0]  w_acc_ext, w_scale_ext, w_bias_ext, w_bn_prod, w_bn_sum;
  logic                    w_bn_fits;
  logic signed [ACC_W-1:0] w_z_nxt;
  assign w_acc_ext   = {{(BN_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
  assign w_scale_ext = {{(BN_W-CFG_W){r_scale[CFG_W-1]}}, r_scale};
  assign w_bias_ext  = {{(BN_W-CFG_W){r_bias[CFG_W-1]}}, r_bias};
  assign w_bn_prod   = w_acc_ext * w_scale_ext;
  assign w_bn_sum    = (w_bn_prod >>> SCALE_SH) + w_bias_ext;
  assign w_bn_fits   = (&w_bn_sum[BN_W-1:ACC_W-1]) | ~(|w_bn_sum[BN_W-1:ACC_W-1]);
  assign w_z_nxt     = w_bn_fits          ? w_bn_sum[ACC_W-1:0] :
                       w_bn_sum[BN_W-1]   ? {1'b1, {(ACC_W-1){1'b0}}} :
                                            {1'b0, {(ACC_W-1){1'b1}}};

  // Activation on z, then drop fractional bits and saturate to 8 bits
  logic signed [ACT_W-1:0] w_z_ext, w_y, w_y_sh;
  logic                    w_y_fits;
  logic signed [OUT_W-1:0] w_out8;
  assign w_z_ext = {{(ACT_W-ACC_W){r_z[ACC_W-1]}}, r_z};

`ifdef CBS_SILU_EN
  localparam logic signed [ACT_W-1:0] FOUR_ONE = ACT_W'(4 << FRAC_BITS);
  logic signed [ACT_W-1:0] w_sq;
  assign w_sq = w_z_ext * (w_z_ext + FOUR_ONE);
  always_comb begin
    w_y = '0;
    if (w_z_ext <= -FOUR_ONE)     w_y = '0;
    else if (w_z_ext >= FOUR_ONE) w_y = w_z_ext;
    else                          w_y = w_sq >>> (FRAC_BITS + 3);
  end
`else
  assign w_y = w_z_ext[ACT_W-1] ? '0 : w_z_ext;
`endif

  assign w_y_sh   = w_y >>> FRAC_BITS;
  assign w_y_fits = (&w_y_sh[ACT_W-1:OUT_W-1]) | ~(|w_y_sh[ACT_W-1:OUT_W-1]);
  assign w_out8   = w_y_fits          ? w_y_sh[OUT_W-1:0] :
                    w_y_sh[ACT_W-1]   ? 8'sh80 : 8'sh7f;

  // Datapath, config bank and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NTAP; k++) begin
        r_pix[k] <= '0;
        r_w[k]   <= '0;
      end
      r_scale     <= 16'sd256;
      r_bias      <= '0;
      r_tap       <= '0;
      r_acc       <= '0;
      r_z         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt == S_IDLE);
      r_cfg_err  <= w_cfg_drop;

      if (w_cfg_wr) begin
        if (bus.cfg_addr < 4'd9)       r_w[bus.cfg_addr] <= bus.cfg_data[7:0];
        else if (bus.cfg_addr == 4'd9)  r_scale <= bus.cfg_data;
        else if (bus.cfg_addr == 4'd10) r_bias  <= bus.cfg_data;
      end

      case (r_state)
        S_IDLE: if (w_accept) begin
          for (int k = 0; k < NTAP; k++) r_pix[k] <= bus.window[PIX_W*k +: PIX_W];
          r_acc <= '0;
          r_tap <= '0;
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          r_tap <= r_tap + 4'd1;
        end
        S_BN:  r_z <= w_z_nxt;
        S_ACT: begin
          r_out_data  <= w_out8;
          r_out_valid <= 1'b1;
        end
        S_HOLD: if (bus.out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.cfg_err   = r_cfg_err;
endmodule

// File: tb/tb_cbs_conv3x3_act.sv
// Self-checking bench for cbs_conv3x3_act: directed spec cases plus randomized windows against a behavioural model.
module tb_cbs_conv3x3_act;
  logic clk;
  logic reset;
  cbs_conv3x3_act_if bus();

  cbs_conv3x3_act dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model copy of the configuration registers
  int tw[9];
  int tscale;
  int tbias;

  function automatic void model_reset();
    for (int k = 0; k < 9; k++) tw[k] = 0;
    tscale = 256;
    tbias  = 0;
  endfunction

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int model(input int pix[9]);
    longint acc, z, y;
    acc = 0;
    for (int k = 0; k < 9; k++) acc += longint'(pix[k]) * longint'(tw[k]);
    z = ((acc * longint'(tscale)) >>> 8) + longint'(tbias);
    z = clamp(z, -(64'sd1 <<< 23), (64'sd1 <<< 23) - 1);
`ifdef CBS_SILU_EN
    if (z <= -64)     y = 0;
    else if (z >= 64) y = z;
    else              y = (z * (z + 64)) >>> 7;
`else
    y = (z < 0) ? 0 : z;
`endif
    y = clamp(y >>> 4, -128, 127);
    return int'(y);
  endfunction

  task automatic cfg_write(input int addr, input int data);
    logic [15:0] d;
    d = 16'(data);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 4'(addr);
    bus.cfg_data = d;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    if (addr < 9)        tw[addr] = int'($signed(d[7:0]));
    else if (addr == 9)  tscale   = int'($signed(d));
    else if (addr == 10) tbias    = int'($signed(d));
  endtask

  task automatic set_all_weights(input int v);
    for (int k = 0; k < 9; k++) cfg_write(k, v);
  endtask

  // Accept one window (optionally with a config write at cycle cfg_at), wait for the result, drain it
  task automatic run_window(input int pix[9], input int cfg_at, input int ca, input int cd,
                            output int lat, output int data, output int err_seen);
    logic [71:0] win;
    for (int k = 0; k < 9; k++) win[8*k +: 8] = 8'(pix[k]);
    bus.window   = win;
    bus.in_valid = 1'b1;
    bus.cfg_addr = 4'(ca);
    bus.cfg_data = 16'(cd);
    if (cfg_at == 0) bus.cfg_we = 1'b1;
    err_seen = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    if (bus.cfg_err) err_seen++;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      if (cfg_at > 0 && lat == cfg_at) bus.cfg_we = 1'b1;
      @(posedge clk); #1;
      lat++;
      bus.cfg_we = 1'b0;
      if (bus.cfg_err) err_seen++;
    end
    data = int'(bus.out_data);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic fill(output int pix[9], input int v);
    for (int k = 0; k < 9; k++) pix[k] = v;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.window    = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    n_total++; if (bus.in_ready !== 1'b1)  $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready);  else n_pass++;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b exp 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.out_data !== 8'sd0) $display("FAIL reset_out_data: got %0d exp 0", bus.out_data); else n_pass++;
    n_total++; if (bus.cfg_err !== 1'b0)   $display("FAIL reset_cfg_err: got %b exp 0", bus.cfg_err);     else n_pass++;
  endtask

  task automatic test_directed();
    int pix[9];
    int lat, data, err;
    int exp_c32, exp_n32;
`ifdef CBS_SILU_EN
    exp_c32 = 1;  exp_n32 = -1;
`else
    exp_c32 = 2;  exp_n32 = 0;
`endif
    set_all_weights(1);
    fill(pix, 10);
    run_window(pix, -1, 0, 0, lat, data, err);
    n_total++; if (lat !== 11)  $display("FAIL lat_ones: got %0d exp 11", lat);   else n_pass++;
    n_total++; if (data !== 5)  $display("FAIL dir_ones: got %0d exp 5", data);   else n_pass++;
    n_total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL drain: got ov=%b ir=%b exp ov=0 ir=1", bus.out_valid, bus.in_ready); else n_pass++;

    set_all_weights(8'hFF);
    run_window(pix, -1, 0, 0, lat, data, err);
    n_total++; if (data !== 0) $display("FAIL dir_neg: got %0d exp 0", data); else n_pass++;

    set_all_weights(0);
    cfg_write(4, 1);
    fill(pix, 0);
    pix[4] = 32;
    run_window(pix, -1, 0, 0, lat, data, err);
    n_total++; if (data !== exp_c32) $display("FAIL dir_c32: got %0d exp %0d", data, exp_c32); else n_pass++;

    cfg_write(4, 8'hFF);
    run_window(pix, -1, 0, 0, lat, data, err);
    n_total++; if (data !== exp_n32) $display("FAIL dir_n32: got %0d exp %0d", data, exp_n32); else n_pass++;

    set_all_weights(127);
    fill(pix, 255);
    run_window(pix, -1, 0, 0, lat, data, err);
    n_total++; if (data !== 127) $display("FAIL dir_sat: got %0d exp 127", data); else n_pass++;

    cfg_write(9, 128);
    cfg_write(10, 16'hF000);
    run_window(pix, -1, 0, 0, lat, data, err);
    n_total++; if (data !== 127) $display("FAIL dir_bn: got %0d exp 127", data); else n_pass++;

    cfg_write(11, 16'h1234);
    run_window(pix, -1, 0, 0, lat, data, err);
    n_total++; if (data !== 127 || err !== 0) $display("FAIL addr11: got d=%0d e=%0d exp d=127 e=0", data, err); else n_pass++;
  endtask

  task automatic test_random();
    int pix[9];
    int lat, data, err, exp_d;
    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < 9; k++) cfg_write(k, int'($urandom_range(0, 255)));
      if (it % 3 == 0) cfg_write(9, int'($urandom_range(0, 65535)));
      else             cfg_write(9, int'($urandom_range(0, 512)));
      if (it % 2 == 0) cfg_write(10, int'($urandom_range(0, 65535)));
      else             cfg_write(10, int'($urandom_range(0, 256)) - 128);
      for (int k = 0; k < 9; k++) pix[k] = int'($urandom_range(0, 255));
      if (it % 4 == 1) for (int k = 0; k < 9; k++) pix[k] = int'($urandom_range(0, 3));
      exp_d = model(pix);
      run_window(pix, -1, 0, 0, lat, data, err);
      n_total++; if (data !== exp_d || lat !== 11)
        $display("FAIL rand_%0d: got d=%0d lat=%0d exp d=%0d lat=11", it, data, lat, exp_d); else n_pass++;
    end
  endtask

  task automatic test_hold();
    int pix_a[9], pix_b[9];
    logic [71:0] win;
    int lat, exp_a, exp_b, bad;
    logic signed [7:0] held;
    set_all_weights(1);
    cfg_write(9, 256);
    cfg_write(10, 0);
    for (int k = 0; k < 9; k++) begin pix_a[k] = 20 + k; pix_b[k] = 40 + 2*k; end
    exp_a = model(pix_a);
    exp_b = model(pix_b);
    for (int k = 0; k < 9; k++) win[8*k +: 8] = 8'(pix_a[k]);
    bus.window = win; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 9; k++) win[8*k +: 8] = 8'(pix_b[k]);
    bus.window = win;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    held = bus.out_data;
    n_total++; if (int'(held) !== exp_a || lat !== 11)
      $display("FAIL hold_first: got d=%0d lat=%0d exp d=%0d lat=11", held, lat, exp_a); else n_pass++;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.in_ready !== 1'b0) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL hold_stable: got %0d bad cycles exp 0", bad); else n_pass++;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL hold_release: got ov=%b ir=%b exp ov=0 ir=1", bus.out_valid, bus.in_ready); else n_pass++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    n_total++; if (int'(bus.out_data) !== exp_b || lat !== 11)
      $display("FAIL hold_next: got d=%0d lat=%0d exp d=%0d lat=11", bus.out_data, lat, exp_b); else n_pass++;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_cfg_err();
    int pix[9];
    int lat, data, err, exp_d;
    set_all_weights(2);
    for (int k = 0; k < 9; k++) pix[k] = 3 * k + 1;
    exp_d = model(pix);
    run_window(pix, 3, 0, 16'h0055, lat, data, err);
    n_total++; if (err !== 1) $display("FAIL cfg_err_mac: got %0d pulses exp 1", err); else n_pass++;
    n_total++; if (data !== exp_d) $display("FAIL cfg_err_mac_data: got %0d exp %0d", data, exp_d); else n_pass++;
    run_window(pix, 0, 1, 16'h0070, lat, data, err);
    n_total++; if (err !== 1) $display("FAIL cfg_err_acc: got %0d pulses exp 1", err); else n_pass++;
    run_window(pix, -1, 0, 0, lat, data, err);
    n_total++; if (data !== exp_d || err !== 0)
      $display("FAIL cfg_unchanged: got d=%0d e=%0d exp d=%0d e=0", data, err, exp_d); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int pix[9];
    int lat, data, err, exp_c32;
    logic [71:0] win;
`ifdef CBS_SILU_EN
    exp_c32 = 1;
`else
    exp_c32 = 2;
`endif
    set_all_weights(5);
    cfg_write(9, 300);
    cfg_write(10, 100);
    for (int k = 0; k < 9; k++) win[8*k +: 8] = 8'(200);
    bus.window = win; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL rst_async: got ov=%b ir=%b exp ov=0 ir=1", bus.out_valid, bus.in_ready); else n_pass++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    n_total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 8'sd0)
      $display("FAIL rst_release: got ov=%b ir=%b d=%0d exp 0/1/0", bus.out_valid, bus.in_ready, bus.out_data); else n_pass++;
    fill(pix, 200);
    run_window(pix, -1, 0, 0, lat, data, err);
    n_total++; if (data !== 0 || lat !== 11) $display("FAIL rst_weights: got d=%0d lat=%0d exp d=0 lat=11", data, lat); else n_pass++;
    cfg_write(4, 1);
    fill(pix, 0);
    pix[4] = 32;
    run_window(pix, -1, 0, 0, lat, data, err);
    n_total++; if (data !== exp_c32) $display("FAIL rst_bn_consts: got %0d exp %0d", data, exp_c32); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_cfg_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end
endmodule
